// File: rtl/sram_data_controller.sv
// -----------------------------------------------------------------------------
// sram_data_controller
//
// Responder side of the MEM-stage data-memory interface. Each 32-bit word
// request from the MEM stage is serviced as two 16-bit accesses to an external
// asynchronous SRAM. The low half goes to the even half-word address and the
// high half to the odd one. The pipeline is held frozen with ready=0 until
// the access completes.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   MEM_R_EN    word read request, held stable while ready=0
//   MEM_W_EN    word write request, held stable while ready=0 (wins over read)
//   address     byte address from the ALU result
//   write_data  store data
//   read_data   registered read result, feeds MEM/WB MEM_R_value
//   ready       0 = freeze the pipeline (combinational)
//   SRAM_DQ     SRAM data bus, tri-stated unless writing
//   SRAM_ADDR   SRAM half-word address
//   SRAM_WE_N   SRAM write enable, active low
//   SRAM_OE_N   SRAM output enable, active low
// -----------------------------------------------------------------------------
module sram_data_controller #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2,  // 1..15 cycles per half access
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  localparam int unsigned    WORD_W     = SRAM_AW - 1;
  localparam logic [3:0]     LAST_COUNT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state;
  logic [3:0]        counter;
  logic              is_write;   // operation latched at the start of an access
  logic [15:0]       dq_out;
  logic              dq_oe;
  logic [WORD_W-1:0] word;
  logic              last_cycle;
  logic              request;

  // Out-of-window addresses wrap silently; address[1:0] is dropped by the shift.
  assign word       = WORD_W'((address - ADDR_BASE) >> 2);
  assign last_cycle = (counter == LAST_COUNT);
  assign request    = MEM_R_EN | MEM_W_EN;
  assign ready      = ~request | (state == DONE);
  assign SRAM_DQ    = dq_oe ? dq_out : 16'bz;

  // The SRAM controls are registered. Each value is therefore loaded on the
  // edge that enters a state, so the pins line up exactly with LOW/HIGH.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so that all
    // right-hand sides see pre-edge values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      is_write  <= 1'b0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            state     <= LOW;
            counter   <= '0;
            is_write  <= MEM_W_EN;
            SRAM_ADDR <= {word, 1'b0};
            SRAM_WE_N <= ~MEM_W_EN;
            SRAM_OE_N <= MEM_W_EN;
            dq_out    <= write_data[15:0];
            dq_oe     <= MEM_W_EN;
          end
        end

        LOW: begin
          if (last_cycle) begin
            state     <= HIGH;
            counter   <= '0;
            SRAM_ADDR <= {word, 1'b1};
            dq_out    <= write_data[31:16];
            if (!is_write) read_data[15:0] <= SRAM_DQ;
          end else begin
            counter <= counter + 4'd1;
          end
        end

        HIGH: begin
          if (last_cycle) begin
            state     <= DONE;
            counter   <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
            if (!is_write) read_data[31:16] <= SRAM_DQ;
          end else begin
            counter <= counter + 4'd1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_data_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_data_controller
//
// Directed bench for sram_data_controller. It uses a 64-half-word behavioural
// SRAM on the tri-state bus and hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_sram_data_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic        SRAM_OE_N;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle trace of one access: index 0 is the IDLE request cycle.
  logic        tr_we   [0:15];
  logic        tr_oe   [0:15];
  logic [17:0] tr_addr [0:15];
  logic [15:0] tr_dq   [0:15];
  int          lat;

  logic [15:0] mem [0:63];

  sram_data_controller dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus on read, stores on a clock with WE_N low.
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[5:0]] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR[5:0]] <= SRAM_DQ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+2 of the cycle the request should appear in. Returns at
  // posedge+2 of the ready (DONE) cycle with the request still asserted.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    MEM_R_EN = r; MEM_W_EN = w; address = a; write_data = d;
    #1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin
        lat = i;
        break;
      end
      if (i < 16) begin
        tr_we[i] = SRAM_WE_N; tr_oe[i] = SRAM_OE_N;
        tr_addr[i] = SRAM_ADDR; tr_dq[i] = SRAM_DQ;
      end
      @(posedge clk); #2;
    end
    check("latency", 32'(lat), 32'd5);
    check("done_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("done_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
  endtask

  task automatic drop_request;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    @(posedge clk); #2;
  endtask

  // Checks the trace of a 5-cycle access at half-word pair lo/lo+1.
  task automatic check_trace(input string tag, input logic w, input logic [17:0] lo,
                             input logic [31:0] d);
    check({tag, "_idle_we"}, {31'd0, tr_we[0]}, 32'd1);
    check({tag, "_idle_oe"}, {31'd0, tr_oe[0]}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(tr_addr[i]), 32'(i <= 2 ? lo : lo + 18'd1));
      check($sformatf("%s_we%0d", tag, i), {31'd0, tr_we[i]}, {31'd0, ~w});
      check($sformatf("%s_oe%0d", tag, i), {31'd0, tr_oe[i]}, {31'd0, w});
      if (w)
        check($sformatf("%s_dq%0d", tag, i), {16'd0, tr_dq[i]},
              {16'd0, (i <= 2) ? d[15:0] : d[31:16]});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
    check("rst_dq_z", {31'd0, SRAM_DQ === 16'bz}, 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    @(posedge clk); #2;

    // Write 0xDEADBEEF to 1028: half-words 2 (BEEF) and 3 (DEAD).
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    check_trace("wr", 1'b1, 18'd2, 32'hDEADBEEF);
    drop_request();
    check("wr_mem2", {16'd0, mem[2]}, 32'h0000BEEF);
    check("wr_mem3", {16'd0, mem[3]}, 32'h0000DEAD);
    check("wr_idle_dq_z", {31'd0, SRAM_DQ === 16'bz}, 32'd1);
    check("wr_read_data", read_data, 32'd0);

    // Read back 1028.
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    check_trace("rd", 1'b0, 18'd2, 32'h0);
    check("rd_data", read_data, 32'hDEADBEEF);
    drop_request();

    // Back-to-back write then read of 1024, one IDLE cycle between them.
    access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D);
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b1;
    @(posedge clk); #2;
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    check_trace("b2b", 1'b0, 18'd0, 32'h0);
    check("b2b_data", read_data, 32'hCAFEF00D);
    drop_request();

    // Reset during HIGH of a read of 1028: the low half is already captured.
    MEM_R_EN = 1'b1; address = 32'd1028;
    repeat (3) begin @(posedge clk); #2; end
    check("mid_low_half", read_data, 32'hCAFEBEEF);
    check("mid_oe_n", {31'd0, SRAM_OE_N}, 32'd0);
    check("mid_addr", 32'(SRAM_ADDR), 32'd3);
    rst = 1'b1; MEM_R_EN = 1'b0;
    @(posedge clk); #2;
    check("abort_read_data", read_data, 32'd0);
    check("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    check("abort_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
    check("abort_dq_z", {31'd0, SRAM_DQ === 16'bz}, 32'd1);
    check("abort_ready", {31'd0, ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #2;
    access(1'b1, 1'b0, 32'd1024, 32'h0);
    check("recover_data", read_data, 32'hCAFEF00D);
    drop_request();

    // Read and write together at 1032: a write to half-words 4/5.
    access(1'b1, 1'b1, 32'd1032, 32'h12345678);
    check_trace("both", 1'b1, 18'd4, 32'h12345678);
    drop_request();
    check("both_mem4", {16'd0, mem[4]}, 32'h00005678);
    check("both_mem5", {16'd0, mem[5]}, 32'h00001234);
    check("both_read_data", read_data, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_data_controller.md
Name: sram_data_controller

Overview:
- Responder side of the MEM-stage data-memory interface.
- Accepts the MEM_R_EN/MEM_W_EN word requests that the MEM stage issues, and services each one as two 16-bit accesses to the external SRAM.
- Holds the pipeline frozen with a low ready until the access completes.
- Read data feeds the MEM_R_value input of the MEM/WB stage registers.

Parameters:
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles spent on each 16-bit half access, legal range 1..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- MEM_R_EN  input  1  word read request, held stable while ready=0
- MEM_W_EN  input  1  word write request, held stable while ready=0
- address  input  32  byte address from the ALU result
- write_data  input  32  store data
- read_data  output  32  registered read result
- ready  output  1  0 = freeze the pipeline
- SRAM_DQ  inout  16  SRAM data bus, tri-stated when not writing
- SRAM_ADDR  output  SRAM_AW  SRAM half-word address
- SRAM_WE_N  output  1  SRAM write enable, active low
- SRAM_OE_N  output  1  SRAM output enable, active low

Behaviour:
- Reset:
  - Synchronous reset to the following values: state=IDLE, counter=0, read_data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - A reset asserted mid-access aborts the access; there is no partial write-back of read_data.
- Address translation:
  - word = (address - ADDR_BASE) >> 2, 32-bit subtraction.
  - Low half uses SRAM_ADDR = {word[SRAM_AW-2:0], 0}.
  - High half uses SRAM_ADDR = {word[SRAM_AW-2:0], 1}.
  - Addresses outside the window wrap silently; address[1:0] is ignored.
- FSM states:
  - IDLE: if MEM_W_EN or MEM_R_EN, go to LOW with counter=0. Otherwise stay in IDLE.
  - LOW: the counter increments each cycle. On counter==WAIT_CYCLES-1, go to HIGH and clear the counter.
  - HIGH: same counting as LOW. On the last cycle go to DONE.
  - DONE: lasts one cycle, then go to IDLE unconditionally.
- Outputs during LOW/HIGH:
  - Write: SRAM_WE_N=0, SRAM_OE_N=1, SRAM_DQ driven with write_data[15:0] in LOW and write_data[31:16] in HIGH.
  - Read: SRAM_WE_N=1, SRAM_OE_N=0, SRAM_DQ=Z.
  - In IDLE/DONE: WE_N=1, OE_N=1, DQ=Z.
- Read capture:
  - On the last cycle of LOW, latch SRAM_DQ into read_data[15:0].
  - On the last cycle of HIGH, latch SRAM_DQ into read_data[31:16].
  - Writes never modify read_data; read_data holds its value until the next read.
- ready (combinational) = !(MEM_R_EN | MEM_W_EN) | (state==DONE).
  - ready stays 1 with no request.
  - With a request, ready is 0 for 2*WAIT_CYCLES+1 cycles, then 1 for exactly one cycle (DONE).
  - Default latency is 6 cycles per access, including the ready cycle.
- Simultaneous MEM_R_EN and MEM_W_EN: treated as a write.
- Back-to-back requests: a request present in the cycle after DONE is a new access and starts from IDLE. The minimum spacing is one IDLE cycle.
- Request dropped mid-access (illegal): the FSM completes its sequence anyway; ready follows the formula above.

Test Plan:
- Idle, no request -> ready=1, WE_N=1, OE_N=1, DQ=Z, read_data=0 after reset.
- Write address=1028, write_data=0xDEADBEEF -> WE_N low 2 cycles at SRAM_ADDR=2 with DQ=0xBEEF, then 2 cycles at SRAM_ADDR=3 with DQ=0xDEAD; ready low 5 cycles, high on the 6th.
- Read address=1028, with the SRAM model holding the write above -> read_data=0xDEADBEEF when ready=1; OE_N low 4 cycles; DQ never driven by the DUT.
- Back-to-back write to 1024 then read of 1024 -> exactly one IDLE cycle between DONE and the next LOW; read returns the written word.
- rst asserted during HIGH of a read -> next cycle state IDLE, read_data=0, WE_N=1, OE_N=1, DQ=Z; the next request completes normally.
- Read and write both asserted with address=1032, write_data=0x12345678 -> write performed at SRAM_ADDR 4/5; read_data unchanged.
